// File: rtl/dma18_bus_master_if.sv
// DMA bus port between the initiator and the CPU board.
// The master side drives the request, address, strobe and write data.
// The slave side returns the grant, the read data and the memory ack.
interface dma18_bus_master_if;
   logic        dma_req;
   logic        dma_ack;
   logic [17:0] dma_adr18;
   logic        dma_stb;
   logic        dma_we;
   logic [15:0] dma_dat_o;
   logic [15:0] dma_dat_i;
   logic        dma_ack_i;

   modport master (
      output dma_req, dma_adr18, dma_stb, dma_we, dma_dat_o,
      input  dma_ack, dma_dat_i, dma_ack_i
   );

   modport slave (
      input  dma_req, dma_adr18, dma_stb, dma_we, dma_dat_o,
      output dma_ack, dma_dat_i, dma_ack_i
   );
endinterface

// File: rtl/dma18_bus_master.sv
// 18-bit DMA initiator with CSR/WC/BA registers, a word FIFO, bounded
// bus tenures, an NXM timeout and a vectored completion interrupt.
module dma18_bus_master #(
   parameter int unsigned DEPTH   = 16,
   parameter int unsigned BURST   = 8,
   parameter int unsigned TIMEOUT = 255,
   parameter logic [8:0]  VECTOR  = 9'o270
) (
   input  logic                wb_clk_i,
   input  logic                wb_rst_i,
   input  logic [1:0]          wb_adr_i,
   input  logic [15:0]         wb_dat_i,
   output logic [15:0]         wb_dat_o,
   input  logic                wb_stb_i,
   input  logic                wb_we_i,
   input  logic [1:0]          wb_sel_i,
   output logic                wb_ack_o,
   dma18_bus_master_if.master  dma,
   input  logic [15:0]         src_dat,
   input  logic                src_valid,
   output logic                src_ready,
   output logic [15:0]         snk_dat,
   output logic                snk_valid,
   input  logic                snk_ready,
   output logic                irq,
   input  logic                istb,
   output logic                iack,
   output logic [8:0]          ivec
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned LW = AW + 1;
   localparam int unsigned TW = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_FILL, S_REQ, S_XFER, S_NEXT, S_REL, S_DRAIN
   } state_t;

   state_t        state;
   logic          func, ie, rdy, nxm, done;
   logic [1:0]    xa;
   logic [15:0]   wc, ba;
   logic          req_q, stb_q, ack_q;
   logic [LW-1:0] bcnt;
   logic [TW-1:0] tcnt;

   logic [15:0]   fifo_mem [DEPTH];
   logic [AW-1:0] wp, rp;
   logic [LW-1:0] level;
   logic          full, empty;

   logic          reg_wr, go_fire, bus_done;
   logic          push, pop;
   logic [15:0]   push_dat;
   logic [15:0]   neg_wc, wc_n;
   logic [16:0]   ba_sum;
   logic [LW-1:0] need, free, bcnt_n;

   assign reg_wr   = wb_stb_i & wb_we_i & ~ack_q;
   assign go_fire  = reg_wr && (wb_adr_i == 2'd0) && wb_sel_i[0] && wb_dat_i[0] && rdy;
   assign bus_done = (state == S_XFER) & stb_q & dma.dma_ack & dma.dma_ack_i;
   assign wb_ack_o = ack_q;

   assign full      = (level == LW'(DEPTH));
   assign empty     = (level == '0);
   assign free      = LW'(DEPTH) - level;
   assign src_ready = ~full & ~rdy & func;
   assign snk_valid = ~empty & ~func;
   assign snk_dat   = snk_valid ? fifo_mem[rp] : '0;

   assign push     = func ? (src_valid & src_ready) : bus_done;
   assign pop      = func ? bus_done : (snk_valid & snk_ready);
   assign push_dat = func ? src_dat : dma.dma_dat_i;

   // Strobe is gated by the grant so it can never appear without dma_ack.
   assign dma.dma_req   = req_q;
   assign dma.dma_stb   = stb_q & dma.dma_ack;
   assign dma.dma_we    = stb_q & func;
   assign dma.dma_adr18 = {xa, ba[15:1], 1'b0};
   assign dma.dma_dat_o = (stb_q & func) ? fifo_mem[rp] : '0;

   assign iack = istb & irq;
   assign ivec = iack ? VECTOR : '0;

   // Burst sizing, word/address advance and register read mux.
   always_comb begin
      neg_wc = 16'd0 - wc;
      wc_n   = wc + 16'd1;
      ba_sum = {1'b0, ba} + 17'd2;
      bcnt_n = bcnt + LW'(1);
      need   = LW'(BURST);
      // WC==0 at FILL only occurs on the first burst and means 65536 words.
      if (wc != '0 && neg_wc < 16'(BURST)) need = neg_wc[LW-1:0];
      wb_dat_o = '0;
      if (wb_stb_i && !wb_we_i) begin
         unique case (wb_adr_i)
            2'd0:    wb_dat_o = {nxm, nxm, 6'd0, rdy, ie, xa, 2'd0, func, 1'b0};
            2'd1:    wb_dat_o = wc;
            2'd2:    wb_dat_o = ba;
            default: wb_dat_o = '0;
         endcase
      end
   end

   // FIFO storage and level; GO flushes it.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i || go_fire) begin
         wp    <= '0;
         rp    <= '0;
         level <= '0;
      end else begin
         if (push) begin
            fifo_mem[wp] <= push_dat;
            wp           <= wp + AW'(1);
         end
         if (pop) rp <= rp + AW'(1);
         unique case ({push, pop})
            2'b10:   level <= level + LW'(1);
            2'b01:   level <= level - LW'(1);
            default: level <= level;
         endcase
      end
   end

   // Register file, interrupt and transfer FSM.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state <= S_IDLE;
         func  <= 1'b0;
         ie    <= 1'b0;
         rdy   <= 1'b1;
         nxm   <= 1'b0;
         done  <= 1'b0;
         xa    <= '0;
         wc    <= '0;
         ba    <= '0;
         req_q <= 1'b0;
         stb_q <= 1'b0;
         ack_q <= 1'b0;
         bcnt  <= '0;
         tcnt  <= '0;
         irq   <= 1'b0;
      end else begin
         ack_q <= wb_stb_i & ~ack_q;
         if (istb) irq <= 1'b0;

         if (reg_wr) begin
            unique case (wb_adr_i)
               2'd0: if (wb_sel_i[0]) begin
                  if (rdy) begin
                     func <= wb_dat_i[1];
                     xa   <= wb_dat_i[5:4];
                  end
                  ie <= wb_dat_i[6];
                  if (!wb_dat_i[6])   irq <= 1'b0;
                  else if (!ie && rdy) irq <= 1'b1;
               end
               2'd1: if (rdy) begin
                  if (wb_sel_i[0]) wc[7:0]  <= wb_dat_i[7:0];
                  if (wb_sel_i[1]) wc[15:8] <= wb_dat_i[15:8];
               end
               2'd2: if (rdy) begin
                  if (wb_sel_i[0]) ba[7:0]  <= wb_dat_i[7:0];
                  if (wb_sel_i[1]) ba[15:8] <= wb_dat_i[15:8];
               end
               default: ;
            endcase
         end

         if (go_fire) begin
            nxm   <= 1'b0;
            rdy   <= 1'b0;
            done  <= 1'b0;
            state <= S_FILL;
         end

         unique case (state)
            S_IDLE: ;
            S_FILL: begin
               if (func ? (level >= need) : (free >= need)) begin
                  bcnt  <= '0;
                  req_q <= 1'b1;
                  state <= S_REQ;
               end
            end
            S_REQ: begin
               if (dma.dma_ack) begin
                  stb_q <= 1'b1;
                  tcnt  <= '0;
                  state <= S_XFER;
               end
            end
            S_XFER: begin
               if (dma.dma_ack && dma.dma_ack_i) begin
                  stb_q <= 1'b0;
                  state <= S_NEXT;
               end else if (!dma.dma_ack) begin
                  stb_q <= 1'b0;
                  state <= S_REQ;
               end else if (tcnt == TW'(TIMEOUT - 1)) begin
                  stb_q <= 1'b0;
                  req_q <= 1'b0;
                  nxm   <= 1'b1;
                  rdy   <= 1'b1;
                  state <= S_IDLE;
                  if (ie) irq <= 1'b1;
               end else begin
                  tcnt <= tcnt + TW'(1);
               end
            end
            S_NEXT: begin
               wc   <= wc_n;
               ba   <= ba_sum[15:0];
               bcnt <= bcnt_n;
               if (ba_sum[16]) xa <= xa + 2'd1;
               if (wc_n == '0) begin
                  done  <= 1'b1;
                  req_q <= 1'b0;
                  state <= S_REL;
               end else if (bcnt_n == LW'(BURST)) begin
                  req_q <= 1'b0;
                  state <= S_REL;
               end else if (dma.dma_ack) begin
                  stb_q <= 1'b1;
                  tcnt  <= '0;
                  state <= S_XFER;
               end else begin
                  state <= S_REQ;
               end
            end
            S_REL: begin
               if (!dma.dma_ack) state <= done ? S_DRAIN : S_FILL;
            end
            S_DRAIN: begin
               if (func || empty) begin
                  rdy   <= 1'b1;
                  state <= S_IDLE;
                  if (ie) irq <= 1'b1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
